// File: rtl/tea_pkg.sv
// Shared definitions for the iterative TEA core.
//   tea_state_e   : control states (IDLE accepts, RUN iterates, DONE presents result)
//   DEFAULT_DELTA : standard TEA round constant
//   tea_sum_init  : starting sum for decryption, (delta*rounds) mod 2^w
package tea_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } tea_state_e;

  localparam logic [31:0] DEFAULT_DELTA = 32'h9E37_79B9;

  // Only the low w bits of the product matter, so the upper bits are cleared
  // explicitly rather than relying on a shifted mask (w may be 64).
  function automatic logic [63:0] tea_sum_init(input logic [63:0] delta,
                                               input int          rounds,
                                               input int          w);
    logic [63:0] p;
    p = delta * 64'(rounds);
    for (int i = 0; i < 64; i++) begin
      if (i >= w) p[i] = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/tea_round.sv
// One full TEA round (both halves plus the sum update), purely combinational.
//   dec_i          : 0 = encrypt round, 1 = decrypt round
//   v0_i, v1_i     : current block halves
//   sum_i          : current sum (pre-update)
//   delta_i        : round constant, already truncated to W bits
//   k0_i..k3_i     : key words
//   v0_o, v1_o     : block halves after the round
//   sum_o          : sum after the round
module tea_round #(
  parameter int W = 32
) (
  input  logic         dec_i,
  input  logic [W-1:0] v0_i,
  input  logic [W-1:0] v1_i,
  input  logic [W-1:0] sum_i,
  input  logic [W-1:0] delta_i,
  input  logic [W-1:0] k0_i,
  input  logic [W-1:0] k1_i,
  input  logic [W-1:0] k2_i,
  input  logic [W-1:0] k3_i,
  output logic [W-1:0] v0_o,
  output logic [W-1:0] v1_o,
  output logic [W-1:0] sum_o
);

  function automatic logic [W-1:0] f_mix(input logic [W-1:0] x,
                                         input logic [W-1:0] s,
                                         input logic [W-1:0] ka,
                                         input logic [W-1:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  logic [W-1:0] s_enc, v0_enc, v1_enc;
  logic [W-1:0] v1_dec, v0_dec;

  // Encrypt: sum advances first, then v0, then v1 from the fresh v0.
  assign s_enc  = sum_i + delta_i;
  assign v0_enc = v0_i + f_mix(v1_i, s_enc, k0_i, k1_i);
  assign v1_enc = v1_i + f_mix(v0_enc, s_enc, k2_i, k3_i);

  // Decrypt mirrors it: v1 first from the old v0, then v0 from the fresh v1,
  // and the sum steps back last.
  assign v1_dec = v1_i - f_mix(v0_i, sum_i, k2_i, k3_i);
  assign v0_dec = v0_i - f_mix(v1_dec, sum_i, k0_i, k1_i);

  assign v0_o  = dec_i ? v0_dec : v0_enc;
  assign v1_o  = dec_i ? v1_dec : v1_enc;
  assign sum_o = dec_i ? (sum_i - delta_i) : s_enc;

endmodule

// File: rtl/tea_iter_core.sv
// Iterative TEA encrypt/decrypt core, one round per clock.
//   clk, rst_n            : clock, synchronous active-low reset
//   start / in_ready      : request handshake (mode, keys, block)
//   e_d                   : 0 = encrypt, 1 = decrypt
//   key0..key3            : key words
//   v0_in, v1_in          : input block halves
//   out_valid / out_ready : result handshake
//   v0_out, v1_out        : working registers (meaningful when out_valid)
//   busy                  : operation in flight (RUN or DONE)
module tea_iter_core
  import tea_pkg::*;
#(
  parameter int          W      = 32,
  parameter int          ROUNDS = 32,
  parameter logic [63:0] DELTA  = 64'(DEFAULT_DELTA)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  input  logic         e_d,
  input  logic [W-1:0] key0,
  input  logic [W-1:0] key1,
  input  logic [W-1:0] key2,
  input  logic [W-1:0] key3,
  input  logic [W-1:0] v0_in,
  input  logic [W-1:0] v1_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] v0_out,
  output logic [W-1:0] v1_out,
  output logic         busy
);

  localparam int           CW       = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST    = CW'(ROUNDS);
  localparam logic [W-1:0] DELTA_W  = DELTA[W-1:0];
  localparam logic [63:0]  SUM_INIT64 = tea_sum_init(DELTA, ROUNDS, W);
  localparam logic [W-1:0] SUM_INIT = SUM_INIT64[W-1:0];

  tea_state_e    state_q, state_d;
  logic          dec_q, dec_d;
  logic [W-1:0]  v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [W-1:0]  k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  logic [W-1:0]  r_v0, r_v1, r_sum;

  tea_round #(.W(W)) u_round (
    .dec_i   (dec_q),
    .v0_i    (v0_q),
    .v1_i    (v1_q),
    .sum_i   (sum_q),
    .delta_i (DELTA_W),
    .k0_i    (k0_q),
    .k1_i    (k1_q),
    .k2_i    (k2_q),
    .k3_i    (k3_q),
    .v0_o    (r_v0),
    .v1_o    (r_v1),
    .sum_o   (r_sum)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    k3_d    = k3_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dec_d   = e_d;
          v0_d    = v0_in;
          v1_d    = v1_in;
          k0_d    = key0;
          k1_d    = key1;
          k2_d    = key2;
          k3_d    = key3;
          sum_d   = e_d ? SUM_INIT : '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        v0_d  = r_v0;
        v1_d  = r_v1;
        sum_d = r_sum;
        cnt_d = cnt_inc;
        // The counter ends at ROUNDS in DONE, hence the ROUNDS+1 range.
        if (cnt_inc == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dec_q   <= 1'b0;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign v0_out    = v0_q;
  assign v1_out    = v1_q;

endmodule

// File: tb/tb_tea_iter_core.sv
// Directed bench for tea_iter_core.
// Instance 0: W=32 ROUNDS=32 default delta. Instance 1: W=8 ROUNDS=32 delta B7.
// Instance 2: W=32 ROUNDS=1 default delta.
module tb_tea_iter_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [3];
  logic        e_d [3];
  logic        out_ready [3];
  logic [31:0] key [3][4];
  logic [31:0] v0i [3];
  logic [31:0] v1i [3];
  logic        in_ready [3];
  logic        out_valid [3];
  logic        busy [3];
  logic [31:0] v0o [3];
  logic [31:0] v1o [3];
  logic [7:0]  b_v0o, b_v1o;

  int n_chk  = 0;
  int n_fail = 0;

  assign v0o[1] = {24'h0, b_v0o};
  assign v1o[1] = {24'h0, b_v1o};

  always #5 clk = ~clk;

  tea_iter_core u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_ready(in_ready[0]),
    .e_d(e_d[0]), .key0(key[0][0]), .key1(key[0][1]), .key2(key[0][2]),
    .key3(key[0][3]), .v0_in(v0i[0]), .v1_in(v1i[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .v0_out(v0o[0]), .v1_out(v1o[0]), .busy(busy[0])
  );

  tea_iter_core #(.W(8), .ROUNDS(32), .DELTA(64'hB7)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_ready(in_ready[1]),
    .e_d(e_d[1]), .key0(key[1][0][7:0]), .key1(key[1][1][7:0]),
    .key2(key[1][2][7:0]), .key3(key[1][3][7:0]),
    .v0_in(v0i[1][7:0]), .v1_in(v1i[1][7:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .v0_out(b_v0o), .v1_out(b_v1o), .busy(busy[1])
  );

  tea_iter_core #(.W(32), .ROUNDS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_ready(in_ready[2]),
    .e_d(e_d[2]), .key0(key[2][0]), .key1(key[2][1]), .key2(key[2][2]),
    .key3(key[2][3]), .v0_in(v0i[2]), .v1_in(v1i[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .v0_out(v0o[2]), .v1_out(v1o[2]), .busy(busy[2])
  );

  // Runs one request on instance d. lat counts clock edges from the accept
  // edge (inclusive) to the edge after which out_valid is seen. With noisy
  // set, start and all inputs are scrambled every cycle while the core works.
  task automatic do_op(input int d, input logic e,
                       input logic [31:0] k0, input logic [31:0] k1,
                       input logic [31:0] k2, input logic [31:0] k3,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit noisy,
                       output logic [31:0] r0, output logic [31:0] r1,
                       output int lat);
    e_d[d] = e;
    key[d][0] = k0; key[d][1] = k1; key[d][2] = k2; key[d][3] = k3;
    v0i[d] = a; v1i[d] = b;
    start[d] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (!out_valid[d] && noisy) begin
        start[d] = 1'b1;
        e_d[d]   = ~e_d[d];
        v0i[d]   = $urandom; v1i[d] = $urandom;
        for (int i = 0; i < 4; i++) key[d][i] = $urandom;
      end else begin
        start[d] = 1'b0;
      end
    end while (!out_valid[d] && lat < 400);
    start[d] = 1'b0;
    r0 = v0o[d];
    r1 = v1o[d];
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b1; out_ready[d] = 1'b1; e_d[d] = 1'b0;
      v0i[d] = 32'h1234_5678; v1i[d] = 32'h9ABC_DEF0;
      for (int i = 0; i < 4; i++) key[d][i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
          v0o[d] !== 32'h0 || v1o[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: rdy=%b vld=%b busy=%b v0=%h v1=%h, want 1 0 0 0 0",
                 d, in_ready[d], out_valid[d], busy[d], v0o[d], v1o[d]);
      end
      start[d] = 1'b0; out_ready[d] = 1'b0;
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b busy=%b, want 1 0", in_ready[0], busy[0]);
    end
  endtask

  task automatic test_encrypt_zero();
    logic [31:0] r0, r1;
    int lat;
    do_op(0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b1, r0, r1, lat);
    n_chk++;
    if (r0 !== 32'h41EA3A0A || r1 !== 32'h94BAA940) begin
      n_fail++;
      $display("FAIL enc_zero: got %h/%h want 41ea3a0a/94baa940", r0, r1);
    end
    n_chk++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL enc_latency: got %0d want 33", lat);
    end
    n_chk++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL enc_release: rdy=%b busy=%b want 1 0", in_ready[0], busy[0]);
    end
  endtask

  task automatic test_decrypt_zero();
    logic [31:0] r0, r1;
    int lat;
    // Issued straight after the previous handshake: back-to-back requests.
    do_op(0, 1'b1, 0, 0, 0, 0, 32'h41EA3A0A, 32'h94BAA940, 1'b0, r0, r1, lat);
    n_chk++;
    if (r0 !== 32'h0 || r1 !== 32'h0) begin
      n_fail++;
      $display("FAIL dec_zero: got %h/%h want 00000000/00000000", r0, r1);
    end
    n_chk++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL dec_latency: got %0d want 33", lat);
    end
  endtask

  task automatic test_hold_done();
    int guard;
    e_d[0] = 1'b0; v0i[0] = 0; v1i[0] = 0;
    for (int i = 0; i < 4; i++) key[0][i] = 0;
    start[0] = 1'b1;
    guard = 0;
    do begin
      @(posedge clk); @(negedge clk);
      start[0] = 1'b0; guard++;
    end while (!out_valid[0] && guard < 400);
    n_chk++;
    if (out_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_reach_done: out_valid=%b after %0d cycles", out_valid[0], guard);
    end
    for (int c = 0; c < 10; c++) begin
      start[0] = 1'b1; out_ready[0] = 1'b0;
      e_d[0] = c[0]; v0i[0] = $urandom; v1i[0] = $urandom;
      for (int i = 0; i < 4; i++) key[0][i] = $urandom;
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 ||
          v0o[0] !== 32'h41EA3A0A || v1o[0] !== 32'h94BAA940) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: vld=%b rdy=%b v=%h/%h want 1 0 41ea3a0a/94baa940",
                 c, out_valid[0], in_ready[0], v0o[0], v1o[0]);
      end
    end
    start[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready[0] = 1'b0;
    n_chk++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drain: rdy=%b busy=%b vld=%b want 1 0 0",
               in_ready[0], busy[0], out_valid[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r0, r1;
    int lat;
    e_d[0] = 1'b0; v0i[0] = 32'hDEAD_BEEF; v1i[0] = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) key[0][i] = 32'h0101_0101 * (i + 1);
    start[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: busy=%b want 1", busy[0]);
    end
    rst_n = 1'b0;
    start[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
        v0o[0] !== 32'h0 || v1o[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: vld=%b busy=%b rdy=%b v=%h/%h want 0 0 1 0/0",
               out_valid[0], busy[0], in_ready[0], v0o[0], v1o[0]);
    end
    rst_n = 1'b1; start[0] = 1'b0; out_ready[0] = 1'b0;
    do_op(0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, r0, r1, lat);
    n_chk++;
    if (r0 !== 32'h41EA3A0A || r1 !== 32'h94BAA940 || lat !== 33) begin
      n_fail++;
      $display("FAIL midrun_after: got %h/%h lat %0d want 41ea3a0a/94baa940 lat 33",
               r0, r1, lat);
    end
  endtask

  task automatic test_w8_roundtrip();
    logic [31:0] k [4];
    logic [31:0] p0, p1, c0, c1, r0, r1;
    int lat_e, lat_d;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 4; i++) k[i] = {24'h0, 8'($urandom)};
      p0 = {24'h0, 8'($urandom)};
      p1 = {24'h0, 8'($urandom)};
      do_op(1, 1'b0, k[0], k[1], k[2], k[3], p0, p1, 1'b0, c0, c1, lat_e);
      do_op(1, 1'b1, k[0], k[1], k[2], k[3], c0, c1, 1'b0, r0, r1, lat_d);
      n_chk++;
      if (r0 !== p0 || r1 !== p1 || lat_e !== 33 || lat_d !== 33) begin
        n_fail++;
        $display("FAIL w8_roundtrip%0d: got %h/%h lat %0d/%0d want %h/%h lat 33/33",
                 n, r0[7:0], r1[7:0], lat_e, lat_d, p0[7:0], p1[7:0]);
      end
    end
  endtask

  task automatic test_rounds1();
    logic [31:0] r0, r1, c0, c1;
    int lat;
    do_op(2, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, r0, r1, lat);
    n_chk++;
    if (r0 !== 32'h9E3779B9 || r1 !== 32'hDBE8D32F) begin
      n_fail++;
      $display("FAIL r1_enc: got %h/%h want 9e3779b9/dbe8d32f", r0, r1);
    end
    n_chk++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL r1_latency: got %0d want 2", lat);
    end
    do_op(2, 1'b1, 0, 0, 0, 0, 32'h9E3779B9, 32'hDBE8D32F, 1'b0, r0, r1, lat);
    n_chk++;
    if (r0 !== 32'h0 || r1 !== 32'h0 || lat !== 2) begin
      n_fail++;
      $display("FAIL r1_dec: got %h/%h lat %0d want 0/0 lat 2", r0, r1, lat);
    end
    do_op(2, 1'b0, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
          32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b0, c0, c1, lat);
    do_op(2, 1'b1, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
          c0, c1, 1'b0, r0, r1, lat);
    n_chk++;
    if (r0 !== 32'hA5A5_5A5A || r1 !== 32'h0F0F_F0F0) begin
      n_fail++;
      $display("FAIL r1_roundtrip: got %h/%h want a5a55a5a/0f0ff0f0", r0, r1);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt_zero();
    test_decrypt_zero();
    test_hold_done();
    test_reset_mid_run();
    test_w8_roundtrip();
    test_rounds1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
